pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage core. It drives the `stall`/`flush` inputs of the PC, IF/ID, ID/EX and EX/MEM pipeline registers. It resolves load-use hazards, EX-stage redirects, multi-cycle mul/div occupancy, and instruction/data memory wait states into a single prioritized decision per cycle. It also keeps saturating stall and redirect performance counters.

---
 rtl/pipeline_hazard_ctrl_if.sv | 51 +++++
 rtl/pipeline_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard controller bundle: pipeline status in, stall/flush/perf out
// Ports (signals):
//   id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2     ID-stage operand info
//   ex_valid, ex_mem_read, ex_rd, ex_muldiv, ex_redirect  EX-stage info
//   imem_ready, mem_req, dmem_ready                       memory wait states
//   pc_stall, *_stall, *_flush                            pipeline register control
//   muldiv_busy, stall_count, redirect_count              status / perf counters
// master: pipeline side (drives status), slave: hazard controller.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             ex_valid;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             ex_muldiv;
  logic             ex_redirect;
  logic             imem_ready;
  logic             mem_req;
  logic             dmem_ready;
  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_stall;
  logic             id_ex_flush;
  logic             ex_mem_stall;
  logic             ex_mem_flush;
  logic             muldiv_busy;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] redirect_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_valid, ex_mem_read, ex_rd, ex_muldiv, ex_redirect,
    output imem_ready, mem_req, dmem_ready,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
    input  ex_mem_stall, ex_mem_flush, muldiv_busy, stall_count, redirect_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_valid, ex_mem_read, ex_rd, ex_muldiv, ex_redirect,
    input  imem_ready, mem_req, dmem_ready,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
    output ex_mem_stall, ex_mem_flush, muldiv_busy, stall_count, redirect_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - prioritized stall/flush controller for the 5-stage core
// Ports:
//   clk      in  clock
//   reset_n  in  asynchronous active-low reset
//   hz       slave modport of pipeline_hazard_ctrl_if (status in, stall/flush/counters out)
// Params: MULDIV_LAT (>=1) cycles a mul/div occupies EX, CNT_W perf counter width.
module pipeline_hazard_ctrl #(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int CW       = $clog2(MULDIV_LAT) + 1;
  // The trigger cycle is the first EX cycle and the cnt==0 cycle is the last,
  // so the counter is loaded with LAT-2 to span exactly MULDIV_LAT cycles.
  localparam int LOAD_VAL = (MULDIV_LAT >= 2) ? MULDIV_LAT - 2 : 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;

  logic mem_wait, load_use, fetch_wait, md_stall;
  logic rs1_hit, rs2_hit;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic ex_mem_stall, ex_mem_flush, redirect_taken;

  always_comb begin
    mem_wait   = hz.mem_req & ~hz.dmem_ready;
    fetch_wait = ~hz.imem_ready;
    rs1_hit    = hz.id_use_rs1 & (hz.id_rs1 == hz.ex_rd);
    rs2_hit    = hz.id_use_rs2 & (hz.id_rs2 == hz.ex_rd);
    load_use   = hz.ex_valid & hz.ex_mem_read & (hz.ex_rd != 5'd0) &
                 hz.id_valid & (rs1_hit | rs2_hit);
  end

  // Mul/div occupancy FSM
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_stall = 1'b0;
    if (MULDIV_LAT > 1) begin
      case (state_q)
        ST_IDLE: begin
          if (hz.ex_valid && hz.ex_muldiv && !mem_wait) begin
            md_stall = 1'b1;
            state_d  = ST_BUSY;
            cnt_d    = CW'(LOAD_VAL);
          end
        end
        ST_BUSY: begin
          if (cnt_q != '0) begin
            // Counting continues through a memory freeze.
            md_stall = 1'b1;
            cnt_d    = cnt_q - CW'(1);
          end else if (!mem_wait) begin
            state_d = ST_IDLE;
          end
          // cnt==0 under mem_wait: linger in BUSY without stalling or re-arming.
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Priority resolution: exactly one rule wins each cycle.
  always_comb begin
    pc_stall       = 1'b0;
    if_id_stall    = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_stall    = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_stall   = 1'b0;
    ex_mem_flush   = 1'b0;
    redirect_taken = 1'b0;
    if (!reset_n) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (mem_wait) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
    end else if (md_stall) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (hz.ex_redirect) begin
      if_id_flush    = 1'b1;
      id_ex_flush    = 1'b1;
      redirect_taken = 1'b1;
    end else if (load_use) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end else if (fetch_wait) begin
      pc_stall    = 1'b1;
      if_id_flush = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    redir_cnt_d = redir_cnt_q;
    if (pc_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (redirect_taken && (redir_cnt_q != '1)) begin
      redir_cnt_d = redir_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign hz.pc_stall       = pc_stall;
  assign hz.if_id_stall    = if_id_stall;
  assign hz.if_id_flush    = if_id_flush;
  assign hz.id_ex_stall    = id_ex_stall;
  assign hz.id_ex_flush    = id_ex_flush;
  assign hz.ex_mem_stall   = ex_mem_stall;
  assign hz.ex_mem_flush   = ex_mem_flush;
  assign hz.muldiv_busy    = (state_q == ST_BUSY);
  assign hz.stall_count    = stall_cnt_q;
  assign hz.redirect_count = redir_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       id_valid, id_use_rs1, id_use_rs2;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_valid, ex_mem_read, ex_muldiv, ex_redirect;
  logic       imem_ready, mem_req, dmem_ready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Three instances share the stimulus: (LAT 4, 32b), (LAT 1, 2b), (LAT 2, 2b).
  pipeline_hazard_ctrl_if #(.CNT_W(32)) if0 ();
  pipeline_hazard_ctrl_if #(.CNT_W(2))  if1 ();
  pipeline_hazard_ctrl_if #(.CNT_W(2))  if2 ();

  pipeline_hazard_ctrl #(.MULDIV_LAT(4), .CNT_W(32)) dut0 (.clk(clk), .reset_n(reset_n), .hz(if0));
  pipeline_hazard_ctrl #(.MULDIV_LAT(1), .CNT_W(2))  dut1 (.clk(clk), .reset_n(reset_n), .hz(if1));
  pipeline_hazard_ctrl #(.MULDIV_LAT(2), .CNT_W(2))  dut2 (.clk(clk), .reset_n(reset_n), .hz(if2));

  assign if0.id_valid = id_valid;      assign if1.id_valid = id_valid;      assign if2.id_valid = id_valid;
  assign if0.id_rs1 = id_rs1;          assign if1.id_rs1 = id_rs1;          assign if2.id_rs1 = id_rs1;
  assign if0.id_rs2 = id_rs2;          assign if1.id_rs2 = id_rs2;          assign if2.id_rs2 = id_rs2;
  assign if0.id_use_rs1 = id_use_rs1;  assign if1.id_use_rs1 = id_use_rs1;  assign if2.id_use_rs1 = id_use_rs1;
  assign if0.id_use_rs2 = id_use_rs2;  assign if1.id_use_rs2 = id_use_rs2;  assign if2.id_use_rs2 = id_use_rs2;
  assign if0.ex_valid = ex_valid;      assign if1.ex_valid = ex_valid;      assign if2.ex_valid = ex_valid;
  assign if0.ex_mem_read = ex_mem_read; assign if1.ex_mem_read = ex_mem_read; assign if2.ex_mem_read = ex_mem_read;
  assign if0.ex_rd = ex_rd;            assign if1.ex_rd = ex_rd;            assign if2.ex_rd = ex_rd;
  assign if0.ex_muldiv = ex_muldiv;    assign if1.ex_muldiv = ex_muldiv;    assign if2.ex_muldiv = ex_muldiv;
  assign if0.ex_redirect = ex_redirect; assign if1.ex_redirect = ex_redirect; assign if2.ex_redirect = ex_redirect;
  assign if0.imem_ready = imem_ready;  assign if1.imem_ready = imem_ready;  assign if2.imem_ready = imem_ready;
  assign if0.mem_req = mem_req;        assign if1.mem_req = mem_req;        assign if2.mem_req = mem_req;
  assign if0.dmem_ready = dmem_ready;  assign if1.dmem_ready = dmem_ready;  assign if2.dmem_ready = dmem_ready;

  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, ex_mem_flush}
  logic [6:0]  ctrl_o [3];
  logic        busy_o [3];
  logic [31:0] sc_o   [3];
  logic [31:0] rc_o   [3];

  assign ctrl_o[0] = {if0.pc_stall, if0.if_id_stall, if0.if_id_flush, if0.id_ex_stall,
                      if0.id_ex_flush, if0.ex_mem_stall, if0.ex_mem_flush};
  assign ctrl_o[1] = {if1.pc_stall, if1.if_id_stall, if1.if_id_flush, if1.id_ex_stall,
                      if1.id_ex_flush, if1.ex_mem_stall, if1.ex_mem_flush};
  assign ctrl_o[2] = {if2.pc_stall, if2.if_id_stall, if2.if_id_flush, if2.id_ex_stall,
                      if2.id_ex_flush, if2.ex_mem_stall, if2.ex_mem_flush};
  assign busy_o[0] = if0.muldiv_busy;
  assign busy_o[1] = if1.muldiv_busy;
  assign busy_o[2] = if2.muldiv_busy;
  assign sc_o[0] = if0.stall_count;
  assign sc_o[1] = 32'(if1.stall_count);
  assign sc_o[2] = 32'(if2.stall_count);
  assign rc_o[0] = if0.redirect_count;
  assign rc_o[1] = 32'(if1.redirect_count);
  assign rc_o[2] = 32'(if2.redirect_count);

  localparam logic [6:0] C_MEMW  = 7'b1101010;
  localparam logic [6:0] C_MD    = 7'b1101001;
  localparam logic [6:0] C_REDIR = 7'b0010100;
  localparam logic [6:0] C_LU    = 7'b1100100;
  localparam logic [6:0] C_FETCH = 7'b1010000;
  localparam logic [6:0] C_RST   = 7'b0010101;

  // Reference model: age = which EX cycle (1..LAT) the current mul/div is in, 0 if none.
  int     lat [3] = '{4, 1, 2};
  int     cw  [3] = '{32, 2, 2};
  int     age [3];
  longint sc  [3];
  longint rc  [3];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_eval(input int i, output logic [6:0] ctrl,
                                     output bit pcs, output bit red, output int nage);
    bit mw, lu;
    int k;
    mw = mem_req && !dmem_ready;
    lu = ex_valid && ex_mem_read && ex_rd != 0 && id_valid &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    k  = (age[i] == 0 && ex_valid && ex_muldiv && !mw) ? 1 : age[i];
    red = 0;
    if (mw)                   ctrl = C_MEMW;
    else if (k > 0 && k < lat[i]) ctrl = C_MD;
    else if (ex_redirect) begin ctrl = C_REDIR; red = 1; end
    else if (lu)              ctrl = C_LU;
    else if (!imem_ready)     ctrl = C_FETCH;
    else                      ctrl = 7'b0;
    pcs = ctrl[6];
    if (k == 0)           nage = 0;
    else if (k < lat[i])  nage = k + 1;
    else                  nage = mw ? k : 0;
  endfunction

  // Called at a negedge with inputs already set; returns at the following negedge.
  task automatic step();
    logic [6:0] ctrl;
    bit pcs [3];
    bit red [3];
    int nage [3];
    longint mx;
    #1;
    for (int i = 0; i < 3; i++) begin
      model_eval(i, ctrl, pcs[i], red[i], nage[i]);
      check_eq($sformatf("ctrl%0d", i), 64'(ctrl_o[i]), 64'(ctrl));
      check_eq($sformatf("busy%0d", i), 64'(busy_o[i]), 64'(age[i] != 0));
      check_eq($sformatf("stall_count%0d", i), 64'(sc_o[i]), 64'(sc[i]));
      check_eq($sformatf("redirect_count%0d", i), 64'(rc_o[i]), 64'(rc[i]));
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      mx = (64'sd1 <<< cw[i]) - 1;
      age[i] = nage[i];
      if (pcs[i] && sc[i] < mx) sc[i]++;
      if (red[i] && rc[i] < mx) rc[i]++;
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_valid = 0; ex_mem_read = 0; ex_rd = 0; ex_muldiv = 0; ex_redirect = 0;
    imem_ready = 1; mem_req = 0; dmem_ready = 1;
  endtask

  // Asserts reset between edges, checks the reset view, releases between edges.
  task automatic do_reset();
    #2 reset_n = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("rst_busy%0d", i), 64'(busy_o[i]), 64'd0);
      check_eq($sformatf("rst_ctrl%0d", i), 64'(ctrl_o[i]), 64'(C_RST));
      check_eq($sformatf("rst_sc%0d", i), 64'(sc_o[i]), 64'd0);
      check_eq($sformatf("rst_rc%0d", i), 64'(rc_o[i]), 64'd0);
      age[i] = 0; sc[i] = 0; rc[i] = 0;
    end
    @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1;
    @(negedge clk);
  endtask

  initial begin
    quiet();
    do_reset();

    // Load-use hit, then same with rd=x0
    ex_valid = 1; ex_mem_read = 1; ex_rd = 5; id_valid = 1; id_rs1 = 5; id_use_rs1 = 1;
    #1 check_eq("load_use", 64'(ctrl_o[0]), 64'(C_LU));
    step();
    ex_rd = 0; id_rs1 = 0;
    #1 check_eq("load_use_x0", 64'(ctrl_o[0]), 64'd0);
    step();

    // Redirect overrides a simultaneous load-use
    ex_rd = 5; id_rs1 = 5; ex_redirect = 1;
    #1 check_eq("redir_over_lu", 64'(ctrl_o[0]), 64'(C_REDIR));
    step();
    check_eq("redir_count", 64'(rc_o[0]), 64'd1);
    quiet();

    // Mul/div occupancy: 3 stall cycles then a free final cycle (LAT=4)
    for (int c = 0; c < 4; c++) begin
      ex_valid = 1; ex_muldiv = 1;
      #1 check_eq($sformatf("md_c%0d", c), 64'(ctrl_o[0]), (c < 3) ? 64'(C_MD) : 64'd0);
      if (c == 0) check_eq("md_lat1", 64'(ctrl_o[1]), 64'd0);
      step();
    end
    quiet();
    #1 check_eq("md_idle_after", 64'(busy_o[0]), 64'd0);
    step();

    // mem_wait on the final mul/div cycle for 2 cycles
    for (int c = 0; c < 6; c++) begin
      ex_valid = 1; ex_muldiv = 1;
      mem_req = (c == 3 || c == 4); dmem_ready = !(c == 3 || c == 4);
      #1;
      if (c == 3 || c == 4) begin
        check_eq($sformatf("freeze_c%0d", c), 64'(ctrl_o[0]), 64'(C_MEMW));
        check_eq($sformatf("freeze_busy%0d", c), 64'(busy_o[0]), 64'd1);
      end
      if (c == 5) check_eq("no_extra_md", 64'(ctrl_o[0]), 64'd0);
      step();
    end
    quiet();
    step();

    // Fetch wait and counter saturation
    do_reset();
    imem_ready = 0;
    repeat (3) step();
    check_eq("fetch_sc3", 64'(sc_o[0]), 64'd3);
    repeat (2) step();
    check_eq("fetch_sc5", 64'(sc_o[0]), 64'd5);
    check_eq("fetch_sat", 64'(sc_o[1]), 64'd3);
    quiet();

    // Reset in the middle of BUSY
    ex_valid = 1; ex_muldiv = 1;
    step();
    check_eq("pre_rst_busy", 64'(busy_o[0]), 64'd1);
    quiet();
    do_reset();
    #1 check_eq("post_rst_ctrl", 64'(ctrl_o[0]), 64'd0);
    step();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      id_valid    = ($urandom_range(3) != 0);
      id_rs1      = 5'($urandom_range(3));
      id_rs2      = 5'($urandom_range(3));
      id_use_rs1  = 1'($urandom);
      id_use_rs2  = 1'($urandom);
      ex_valid    = ($urandom_range(4) != 0);
      ex_mem_read = 1'($urandom);
      ex_rd       = 5'($urandom_range(3));
      ex_muldiv   = ($urandom_range(7) == 0);
      ex_redirect = !ex_muldiv && ($urandom_range(7) == 0);
      imem_ready  = ($urandom_range(4) != 0);
      mem_req     = ($urandom_range(2) == 0);
      dmem_ready  = 1'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
